// File: rtl/add32_seq_ctrl_pkg.sv
// Shared types and default widths for the serialised add/subtract controller.
package add32_seq_ctrl_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned SLICE_W_DEF = 8;
    localparam int unsigned ID_W        = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add32_seq_ctrl_cla8_slice.sv
// Combinational carry-lookahead slice adder shared by all passes of an operation.
module cla8_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         cy;
    logic         pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat OR of every generate propagated up to this bit, plus cin.
    always_comb begin
        c    = '0;
        cy   = 1'b0;
        pp   = 1'b1;
        c[0] = cin;
        for (int i = 0; i < int'(W); i++) begin
            cy = 1'b0;
            pp = 1'b1;
            for (int k = i; k >= 0; k--) begin
                cy = cy | (pp & g[k]);
                pp = pp & p[k];
            end
            c[i+1] = cy | (pp & cin);
        end
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];

endmodule

// File: rtl/add32_seq_ctrl.sv
// Round-robin two-requester add/subtract controller that walks one narrow
// lookahead slice across the operand, one slice per cycle.
module add32_seq_ctrl
    import add32_seq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SLICE_W = SLICE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic              r0_sub,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic              r1_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_ovf,
    output logic              busy
);

    localparam int unsigned NSLICE = DATA_W / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned MSB    = DATA_W - 1;

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                carry_q, carry_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                gnt_vld_c;
    logic                gnt_c;
    logic [SLICE_W-1:0]  slice_a, slice_b, slice_sum;
    logic                slice_cout;
    logic                done;

    // Round-robin: the requester not served last has priority; reset blocks grants.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_c     = ~last_q;
        if ((state_q == ST_IDLE) && !rst) begin
            if (last_q ? r0_valid : r1_valid) begin
                gnt_vld_c = 1'b1;
                gnt_c     = ~last_q;
            end else if (last_q ? r1_valid : r0_valid) begin
                gnt_vld_c = 1'b1;
                gnt_c     = last_q;
            end
        end
    end

    assign r0_ready = gnt_vld_c & ~gnt_c;
    assign r1_ready = gnt_vld_c &  gnt_c;

    assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

    cla8_slice #(.W(SLICE_W)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld_c) begin
                    a_d     = gnt_c ? r1_a : r0_a;
                    b_d     = gnt_c ? (r1_sub ? ~r1_b : r1_b) : (r0_sub ? ~r0_b : r0_b);
                    carry_d = gnt_c ? r1_sub : r0_sub;
                    id_d    = ID_W'(gnt_c);
                    idx_d   = '0;
                    last_d  = gnt_c;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // Response fields are only exposed while a finished result is held.
    assign done      = (state_q == ST_DONE);
    assign rsp_valid = done;
    assign rsp_id    = done ? id_q : '0;
    assign rsp_sum   = done ? res_q : '0;
    assign rsp_cout  = done & carry_q;
    assign rsp_ovf   = done & (a_q[MSB] == b_q[MSB]) & (res_q[MSB] != a_q[MSB]);
    assign busy      = (state_q != ST_IDLE);

endmodule
